// File: rtl/spi_adc_scanner.sv
// SPI master for serial ADCs: scans the enabled channels once or continuously.
// Each result is reported with its channel tag, and a per-channel threshold flag is latched.
module spi_adc_scanner #(
  parameter int DATA_W  = 12,
  parameter int NUM_CH  = 2,
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic              cont,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [DATA_W-1:0] thresh,
  input  logic              miso,
  output logic              sck,
  output logic              cs_n,
  output logic              mosi,
  output logic [DATA_W-1:0] data,
  output logic [CH_W-1:0]   data_ch,
  output logic              data_valid,
  output logic [NUM_CH-1:0] above,
  output logic              busy
);

  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

  if (1 + CH_W + DATA_W > FRAME_W) begin : g_bad_frame
    $error("FRAME_W too small for start bit, channel field and result");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("CLK_DIV must be at least 2");
  end

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [CH_W-1:0]     ptr, cur_ch, ptr_adv, sel_from, ch_sel;
  logic [NUM_CH-1:0]   pending, remaining, sel_mask;
  logic [FRAME_W-1:0]  tx;
  logic [DATA_W-1:0]   rx;

  // Lowest set index at or above 'from', wrapping around to the lowest set index.
  function automatic logic [CH_W-1:0] pick(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] from);
    logic [CH_W-1:0] lo, hi;
    logic            hit;
    lo  = '0;
    hi  = '0;
    hit = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) begin
        lo = CH_W'(i);
        if (i >= int'(from)) begin
          hi  = CH_W'(i);
          hit = 1'b1;
        end
      end
    end
    return hit ? hi : lo;
  endfunction

  function automatic logic [FRAME_W-1:0] cmd_word(input logic [CH_W-1:0] ch);
    cmd_word = '0;
    cmd_word[FRAME_W-1] = 1'b1;
    cmd_word[FRAME_W-2 -: CH_W] = ch;
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latch).
    state_d   = state;
    ptr_adv   = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
    remaining = pending & ~(NUM_CH'(1) << cur_ch);
    sel_mask  = ch_mask;
    sel_from  = ptr;
    unique case (state)
      IDLE:  if (en && (start || cont) && (|ch_mask)) state_d = SETUP;
      SETUP: if (cnt == HALF_END) state_d = SHIFT;
      SHIFT: if (cnt == BIT_END && bit_cnt == LAST_BIT) state_d = DONE;
      DONE:  state_d = GAP;
      GAP: begin
        if (cnt == HALF_END) begin
          sel_from = ptr_adv;
          if (en && (|remaining)) begin
            sel_mask = remaining;
            state_d  = SETUP;
          end else if (en && cont && (|ch_mask)) begin
            state_d  = SETUP;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ch_sel = pick(sel_mask, sel_from);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      ptr        <= '0;
      cur_ch     <= '0;
      pending    <= '0;
      tx         <= '0;
      rx         <= '0;
      sck        <= 1'b0;
      cs_n       <= 1'b1;
      mosi       <= 1'b0;
      data       <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
      above      <= '0;
    end else begin
      data_valid <= 1'b0;
      cnt        <= cnt + 1'b1;
      unique case (state)
        IDLE: cnt <= '0;
        SETUP: begin
          if (cnt == HALF_END) begin
            cnt     <= '0;
            bit_cnt <= '0;
            sck     <= 1'b1;
            rx      <= DATA_W'({rx, miso});
          end
        end
        SHIFT: begin
          if (cnt == HALF_END) begin
            sck  <= 1'b0;
            mosi <= tx[FRAME_W-1];
            tx   <= tx << 1;
          end else if (cnt == BIT_END) begin
            cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              cs_n <= 1'b1;
              mosi <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sck     <= 1'b1;
              rx      <= DATA_W'({rx, miso});
            end
          end
        end
        DONE: begin
          cnt           <= '0;
          data          <= rx;
          data_ch       <= cur_ch;
          data_valid    <= 1'b1;
          above[cur_ch] <= (rx >= thresh);
        end
        GAP: if (cnt == HALF_END) ptr <= ptr_adv;
        default: cnt <= '0;
      endcase
      // Frame launch, from IDLE or at the end of GAP: the command MSB is always the start bit.
      if (state_d == SETUP && state != SETUP) begin
        cnt     <= '0;
        cs_n    <= 1'b0;
        sck     <= 1'b0;
        mosi    <= 1'b1;
        tx      <= cmd_word(ch_sel) << 1;
        cur_ch  <= ch_sel;
        pending <= sel_mask;
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Self-checking bench for spi_adc_scanner: serial ADC model plus a scoreboard of
// expected (channel, result) pairs pushed at stimulus time and popped on data_valid.
module tb_spi_adc_scanner;

  localparam int DATA_W  = 12;
  localparam int NUM_CH  = 2;
  localparam int FRAME_W = 16;
  localparam int CLK_DIV = 4;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LAT     = CLK_DIV + 2 * CLK_DIV * FRAME_W + 1;
  localparam int PERIOD  = LAT + CLK_DIV;

  logic              clk = 1'b0;
  logic              rst_n, en, start, cont;
  logic [NUM_CH-1:0] ch_mask;
  logic [DATA_W-1:0] thresh;
  logic              miso = 1'b0;
  logic              sck, cs_n, mosi, data_valid, busy;
  logic [DATA_W-1:0] data;
  logic [CH_W-1:0]   data_ch;
  logic [NUM_CH-1:0] above;

  spi_adc_scanner #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .FRAME_W(FRAME_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .cont(cont), .ch_mask(ch_mask),
    .thresh(thresh), .miso(miso), .sck(sck), .cs_n(cs_n), .mosi(mosi), .data(data),
    .data_ch(data_ch), .data_valid(data_valid), .above(above), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] val;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  int                checks = 0, failures = 0;
  int                cyc = 0, frames = 0, last_dv = 0, prev_dv = -1;
  bit                check_period = 1'b0;
  int                mptr = 0;
  int                gap_run = 0, min_gap = 1000;
  logic [NUM_CH-1:0] exp_above = '0;
  logic [DATA_W-1:0] adc_val [NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [FRAME_W-1:0] exp_cmd(input logic [CH_W-1:0] ch);
    logic [FRAME_W-1:0] c;
    c = '0;
    c[FRAME_W-1] = 1'b1;
    c[FRAME_W-2 -: CH_W] = ch;
    return c;
  endfunction

  function automatic int pick_model(input logic [NUM_CH-1:0] m, input int from);
    for (int k = 0; k < NUM_CH; k++) begin
      if (m[(from + k) % NUM_CH]) return (from + k) % NUM_CH;
    end
    return 0;
  endfunction

  task automatic push_pass(input logic [NUM_CH-1:0] mask);
    logic [NUM_CH-1:0] rem;
    exp_t              e;
    int                ch;
    rem = mask;
    while (rem != '0) begin
      ch    = pick_model(rem, mptr);
      e.ch  = CH_W'(ch);
      e.val = adc_val[ch];
      sb.push_back(e);
      rem[ch] = 1'b0;
      mptr    = (ch + 1) % NUM_CH;
    end
  endtask

  // ADC model: decodes the command on sck rises, shifts the result out on sck falls.
  int                rise_cnt = 0, ch_dec = 0;
  logic [FRAME_W-1:0] cmd_rx = '0;

  always @(posedge sck or negedge cs_n) begin
    if (sck) begin
      cmd_rx = {cmd_rx[FRAME_W-2:0], mosi};
      rise_cnt++;
      if (rise_cnt == 1 + CH_W) ch_dec = int'(cmd_rx[CH_W-1:0]);
    end else begin
      rise_cnt = 0;
      cmd_rx   = '0;
    end
  end

  always @(negedge sck) begin
    if (rise_cnt >= FRAME_W - DATA_W && rise_cnt < FRAME_W && ch_dec < NUM_CH)
      miso = adc_val[ch_dec][FRAME_W - 1 - rise_cnt];
    else
      miso = 1'b0;
  end

  always @(posedge clk) cyc++;

  // Output monitor: scoreboard compare, frame spacing and chip-select deselect time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && cs_n) gap_run++;
      else if (!cs_n && gap_run > 0) begin
        if (gap_run < min_gap) min_gap = gap_run;
        gap_run = 0;
      end
      if (data_valid) begin
        frames++;
        if (check_period && prev_dv >= 0) check("frame_period", cyc - prev_dv, PERIOD);
        prev_dv = cyc;
        last_dv = cyc;
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          exp_above[mon_e.ch] = (mon_e.val >= thresh);
          check("data_ch", data_ch, mon_e.ch);
          check("data", data, mon_e.val);
          check("mosi_cmd", cmd_rx, exp_cmd(mon_e.ch));
          check("above", above, exp_above);
        end
      end
    end
  end

  task automatic do_reset(input bit verify);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    if (verify) begin
      check("rst_sck", sck, 0);
      check("rst_cs_n", cs_n, 1);
      check("rst_mosi", mosi, 0);
      check("rst_data", data, 0);
      check("rst_data_ch", data_ch, 0);
      check("rst_valid", data_valid, 0);
      check("rst_above", above, 0);
      check("rst_busy", busy, 0);
    end
    sb.delete();
    mptr = 0;
    exp_above = '0;
    prev_dv = -1;
    check_period = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(output int launch);
    @(negedge clk);
    start  = 1'b1;
    launch = cyc + 1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_in_time"}, n < budget, 1);
  endtask

  int L, f0, n;

  initial begin
    en = 1'b0; start = 1'b0; cont = 1'b0; ch_mask = '0; thresh = '0;
    adc_val[0] = '0; adc_val[1] = '0;

    // Single shot on ch0: latency, result and busy release.
    do_reset(1'b1);
    en = 1'b1; thresh = 12'h800; adc_val[0] = 12'hABC; adc_val[1] = 12'h5A5; ch_mask = 2'b01;
    f0 = frames;
    push_pass(2'b01);
    pulse_start(L);
    n = 0;
    while (frames == f0 && n < 400) begin @(negedge clk); n++; end
    check("s1_frame_seen", n < 400, 1);
    check("s1_latency", last_dv - L, LAT);
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    check("s1_busy_fall", cyc - last_dv, CLK_DIV);
    check("s1_frames", frames - f0, 1);

    // Two-channel pass: ordering, thresholds, deselect time between frames.
    do_reset(1'b0);
    ch_mask = 2'b11; adc_val[0] = 12'h123; adc_val[1] = 12'hFFF;
    gap_run = 0; min_gap = 1000; f0 = frames;
    push_pass(2'b11);
    pulse_start(L);
    wait_idle("s2", 600);
    check("s2_above", above, 2'b10);
    check("s2_gap_ge_div", min_gap >= CLK_DIV, 1);
    check("s2_frames", frames - f0, 2);

    // Continuous scan of ch1 only, then drop cont mid-frame.
    adc_val[1] = 12'h5A5; ch_mask = 2'b10; f0 = frames;
    for (int i = 0; i < 4; i++) push_pass(2'b10);
    @(negedge clk);
    cont = 1'b1; prev_dv = -1; check_period = 1'b1;
    repeat (3 * PERIOD + 50) @(negedge clk);
    cont = 1'b0;
    wait_idle("s3", 400);
    check_period = 1'b0;
    repeat (300) @(negedge clk);
    check("s3_frames", frames - f0, 4);
    check("s3_idle", busy, 0);

    // Asynchronous reset in SHIFT bit 7, then the next pass starts at ch0.
    do_reset(1'b0);
    ch_mask = 2'b01;
    push_pass(2'b01);
    pulse_start(L);
    wait_idle("s4a", 300);
    ch_mask = 2'b11; f0 = frames;
    pulse_start(L);
    while (cyc < L + CLK_DIV + 7 * 2 * CLK_DIV + 2) @(negedge clk);
    check("s4_in_frame", cs_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("s4_rst_cs_n", cs_n, 1);
    check("s4_rst_sck", sck, 0);
    check("s4_rst_busy", busy, 0);
    sb.delete(); mptr = 0; exp_above = '0; prev_dv = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("s4_no_partial", frames - f0, 0);
    check("s4_above_cleared", above, 0);
    push_pass(2'b11);
    pulse_start(L);
    wait_idle("s4b", 600);
    check("s4_frames", frames - f0, 2);

    // Empty mask never launches; start while busy is ignored.
    ch_mask = 2'b00; f0 = frames;
    pulse_start(L);
    repeat (20) @(negedge clk);
    check("s5_mask0_busy", busy, 0);
    check("s5_mask0_frames", frames - f0, 0);
    ch_mask = 2'b01;
    push_pass(2'b01);
    pulse_start(L);
    repeat (50) @(negedge clk);
    pulse_start(L);
    wait_idle("s5", 400);
    repeat (20) @(negedge clk);
    check("s5_busy_start_ignored", frames - f0, 1);

    // Threshold boundary: equal sets the flag, one below clears it.
    thresh = 12'h800; adc_val[0] = 12'h800;
    push_pass(2'b01);
    pulse_start(L);
    wait_idle("s6a", 300);
    check("s6_eq_thresh", above[0], 1);
    adc_val[0] = 12'h7FF;
    push_pass(2'b01);
    pulse_start(L);
    wait_idle("s6b", 300);
    check("s6_below_thresh", above[0], 0);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
